// File: rtl/mul_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
//   Shared widths and helpers for the multiplier-sharing arbiter.
//   OP_W         : operand width of the shared multiplier
//   P_W          : product width
//   NREQ_DEFAULT : default requester count
//   calc_idw()   : requester-ID width for a given requester count
// -----------------------------------------------------------------------------
package mul_share_pkg;

    localparam int OP_W         = 8;
    localparam int P_W          = 16;
    localparam int NREQ_DEFAULT = 4;

    // Never narrower than one bit, so a 2-requester build still has an ID bit.
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// -----------------------------------------------------------------------------
// mul_share_if
//   Requester and response channels of the multiplier-sharing arbiter.
//   req_valid/req_ready : per-requester handshake
//   req_x/req_y         : packed operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id/rsp_p        : owner index and signed product
//   slave  : arbiter side
//   master : requester/consumer side
// -----------------------------------------------------------------------------
interface mul_share_if
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
);

    localparam int IDW = calc_idw(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [OP_W*NREQ-1:0] req_x;
    logic [OP_W*NREQ-1:0] req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [P_W-1:0]       rsp_p;

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/mul_share_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin selector. The winner is the first set req bit at or after
//   rr_ptr, scanning upward and wrapping. The pointer moves past the winner
//   only when a grant is actually taken (|gnt & en).
//   clk    : system clock
//   rst    : synchronous active-high reset (rr_ptr -> 0)
//   req    : candidate bits
//   en     : grant is being consumed this cycle
//   gnt    : one-hot winner (zero when no candidate)
//   gnt_id : encoded winner
// -----------------------------------------------------------------------------
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    localparam int IDW = calc_idw(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW:0]   idx_w;
    logic [IDW-1:0] idx;
    logic           found;

    // One extra bit on idx_w so rr_ptr + k cannot overflow before the wrap.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        gnt    = '0;
        idx_w  = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NREQ)) begin
                idx_w = idx_w - (IDW+1)'(NREQ);
            end
            idx = idx_w[IDW-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((|gnt) && en) begin
            rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
//   Shares one external 8x8 signed combinational multiplier among NREQ
//   requesters. Two-stage pipeline: S1 registers the winning operands and
//   drives them to the multiplier; S2 registers the product with its owner ID
//   and presents it on the response channel. Two ops in flight at most.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset; in-flight ops are dropped
//   bus   : mul_share_if.slave (requests in, responses out)
//   mul_x : operand to external multiplier (S1 register)
//   mul_y : operand to external multiplier (S1 register)
//   mul_p : combinational product from external multiplier
//   busy  : any stage holds a valid op
// -----------------------------------------------------------------------------
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    localparam int IDW = calc_idw(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    mul_share_if.slave       bus,
    output logic [OP_W-1:0]  mul_x,
    output logic [OP_W-1:0]  mul_y,
    input  logic [P_W-1:0]   mul_p,
    output logic             busy
);

    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q,    s1_id_d;
    logic [OP_W-1:0] s1_x_q,     s1_x_d;
    logic [OP_W-1:0] s1_y_q,     s1_y_d;

    logic            s2_valid_q, s2_valid_d;
    logic [IDW-1:0]  s2_id_q,    s2_id_d;
    logic [P_W-1:0]  s2_p_q,     s2_p_d;

    logic            adv2;
    logic            acc1;
    logic            arb_en;
    logic            grant;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [OP_W-1:0] x_sel;
    logic [OP_W-1:0] y_sel;

    // S2 takes the S1 op when S2 is empty or its result is leaving now;
    // S1 can accept whenever it is empty or is emptying into S2.
    assign adv2   = s1_valid_q & (~s2_valid_q | bus.rsp_ready);
    assign acc1   = ~s1_valid_q | adv2;
    assign arb_en = acc1 & ~rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign bus.req_ready = gnt & {NREQ{arb_en}};
    assign grant         = |(bus.req_valid & bus.req_ready);

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                x_sel = bus.req_x[i*OP_W +: OP_W];
                y_sel = bus.req_y[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        if (grant) begin
            s1_valid_d = 1'b1;
            s1_id_d    = gnt_id;
            s1_x_d     = x_sel;
            s1_y_d     = y_sel;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_p_d     = s2_p_q;
        if (adv2) begin
            s2_valid_d = 1'b1;
            s2_id_d    = s1_id_q;
            s2_p_d     = mul_p;
        end else if (s2_valid_q && bus.rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_p_q     <= s2_p_d;
        end
    end

    assign mul_x         = s1_x_q;
    assign mul_y         = s1_y_q;
    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_p     = s2_p_q;
    assign busy          = s1_valid_q | s2_valid_q;

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one 8x8 signed combinational Wallace multiplier (the datapath's product unit) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes per requester.
- Registers the winning operands, drives them to the multiplier, and registers the 16-bit product with the requester's ID.
- Returns the result on a single valid/ready response channel; sits between requester blocks and the multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), derived localparam; response ID width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_x  input  8*NREQ  packed multiplicands; requester i at [8i+7:8i]; two's complement.
- req_y  input  8*NREQ  packed multipliers; same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that owns rsp_p.
- rsp_p  output  16  signed product x*y.
- mul_x  output  8  operand to external multiplier.
- mul_y  output  8  operand to external multiplier.
- mul_p  input  16  combinational product from external multiplier.
- busy  output  1  any stage holds a valid op.

Behaviour:
- Reset (clk edge with rst=1): s1_valid=0, s2_valid=0, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_p=0, mul_x=0, mul_y=0, busy=0. req_ready is combinational and is 0 while rst=1.
- Reset mid-operation: all in-flight ops are discarded without response. Requesters see no handshake for them and must re-issue.
- Pipeline stage S1: operand register {s1_valid, s1_id, s1_x, s1_y}. mul_x=s1_x and mul_y=s1_y, driven directly from the registers.
- Pipeline stage S2: result register {s2_valid, s2_id, s2_p}. rsp_valid=s2_valid, rsp_id=s2_id, rsp_p=s2_p.
- S2 load enable: adv2 = s1_valid & (!s2_valid | rsp_ready). On adv2: s2_p<=mul_p, s2_id<=s1_id, s2_valid<=1.
- S2 clear: if s2_valid & rsp_ready & !adv2, then s2_valid<=0.
- S1 accept enable: acc1 = !s1_valid | adv2.
- Arbitration:
  - Candidates are req_valid bits.
  - Winner is the first set bit at or after rr_ptr, scanning upward and wrapping mod NREQ.
  - req_ready[winner]=acc1; all other req_ready bits are 0.
  - req_ready must not depend on req_valid of non-winners. It may depend on the winner's req_valid via the priority scan.
- Grant: on req_valid[w] & req_ready[w]:
  - S1 <= {1, w, x_w, y_w}.
  - rr_ptr <= (w+1) mod NREQ.
- S1 clear: if adv2 and no grant, s1_valid<=0. rr_ptr is unchanged when there is no grant.
- Latency: grant at edge N makes rsp_valid=1 after edge N+1, i.e. 2 cycles from handshake to result.
- Throughput: 1 op/cycle with rsp_ready held high.
- Back-pressure:
  - rsp_ready=0 with S2 full holds rsp_* stable.
  - S1 then holds; once S1 is also full, all req_ready=0.
  - Capacity is 2 in-flight ops.
  - Simultaneous rsp_ready=1 and new data: S2 reloads in the same cycle; no bubble.
- Fairness: a requester holding req_valid high is granted within NREQ grants.
- Arithmetic: product is signed two's complement 16-bit. Range is -16256..16384; -128*-128 = 0x4000.
- rsp_p equals mul_p sampled at the adv2 edge; the block performs no arithmetic itself.
- Requester protocol: req_x/req_y must stay stable while req_valid=1 and not yet granted. The block does not check this.

Decomposition:
- Package mul_share_pkg holds OP_W=8, P_W=16, NREQ_DEFAULT=4 and the IDW calculation function.
- Sub-module rr_arbiter(NREQ):
  - Inputs: clk, rst, req, en.
  - Outputs: one-hot gnt, encoded gnt_id.
  - Owns rr_ptr, which updates only on (|gnt) & en.
- The multiplier is instantiated beside this block at the parent level, not inside it.

Test Plan:
- Requester 0 sends x=3, y=5, others idle, rsp_ready=1 → req_ready[0]=1 for one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_p=0x000F.
- Signed corners, serially on requester 2: (-128,-128), (-1,1), (127,-128) → rsp_p = 0x4000, 0xFFFF, 0xC080, all with rsp_id=2, in order.
- All 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…; one response per cycle; each rsp_p matches its requester's operands.
- rsp_ready=0 for 5 cycles with 4 requesters valid → exactly 2 grants, then req_ready all 0; rsp_* stable. On rsp_ready=1, in-order drain with no loss or duplication.
- rst=1 for 1 cycle with S1 and S2 full → next cycle rsp_valid=0, busy=0. Next grant goes to requester 0 when all are valid, since rr_ptr=0.
- Only requester 3 valid after requester 1 was last granted (rr_ptr=2) → wrap scan grants 3; rr_ptr becomes 0.
